// File: rtl/axis_frame_gen_pkg.sv
// Shared types and helpers for the AXI-Stream frame generator: state encoding,
// tkeep mask construction and the deterministic byte-pattern beat builder.
package axis_frame_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int MAX_KEEP_WIDTH = 64;
    localparam int MAX_DATA_WIDTH = MAX_KEEP_WIDTH * 8;

    // Low `count` bits set; callers narrow the result to their own lane count.
    function automatic logic [MAX_KEEP_WIDTH-1:0] keep_mask(input logic [31:0] count);
        logic [MAX_KEEP_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_KEEP_WIDTH; i++) begin
            if (32'(i) < count) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Lane k carries first+k (mod 256) for the first `count` lanes, zero above.
    function automatic logic [MAX_DATA_WIDTH-1:0] pattern_beat(input logic [7:0]  first,
                                                               input logic [31:0] count);
        logic [MAX_DATA_WIDTH-1:0] d;
        d = '0;
        for (int k = 0; k < MAX_KEEP_WIDTH; k++) begin
            if (32'(k) < count) begin
                d[8*k +: 8] = first + 8'(k);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame source: one pattern frame per accepted command, one beat per
// cycle, with tkeep/tlast/tid/tdest/tuser and frame completion bookkeeping.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int                      DATA_WIDTH           = 8,
    parameter bit                      KEEP_ENABLE          = (DATA_WIDTH > 8),
    parameter int                      KEEP_WIDTH           = DATA_WIDTH / 8,
    parameter int                      ID_WIDTH             = 8,
    parameter int                      DEST_WIDTH           = 8,
    parameter int                      USER_WIDTH           = 1,
    parameter logic [USER_WIDTH-1:0]   USER_BAD_FRAME_VALUE = USER_WIDTH'(1),
    parameter int                      LEN_WIDTH            = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic [7:0]             cmd_seed,
    input  logic [ID_WIDTH-1:0]    cmd_id,
    input  logic [DEST_WIDTH-1:0]  cmd_dest,
    input  logic                   cmd_bad,

    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [ID_WIDTH-1:0]    m_axis_tid,
    output logic [DEST_WIDTH-1:0]  m_axis_tdest,
    output logic [USER_WIDTH-1:0]  m_axis_tuser,

    output logic                   busy,
    output logic                   frame_done,
    output logic [31:0]            frame_count
);

    // Without tkeep every beat counts as a single unit of length.
    localparam int                   LANES      = KEEP_ENABLE ? KEEP_WIDTH : 1;
    localparam logic [LEN_WIDTH-1:0] LANES_LEN  = LEN_WIDTH'(LANES);
    localparam logic [7:0]           LANES_BYTE = 8'(LANES);

    state_t                  state;
    logic [LEN_WIDTH-1:0]    remaining;
    logic [7:0]              pattern;
    logic                    bad_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [DEST_WIDTH-1:0]   dest_q;

    logic                    load;
    logic                    is_final;
    logic                    last_hs;
    logic [31:0]             beat_bytes;
    logic [KEEP_WIDTH-1:0]   final_keep;

    assign load       = (state == ST_SEND) && (m_axis_tready || !m_axis_tvalid);
    assign is_final   = (remaining <= LANES_LEN);
    assign last_hs    = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign beat_bytes = is_final ? 32'(remaining) : 32'(LANES);
    assign final_keep = KEEP_ENABLE ? KEEP_WIDTH'(keep_mask(32'(remaining)))
                                    : {KEEP_WIDTH{1'b1}};

    // Command FSM and output register. The FSM drops back to IDLE as soon as the
    // final beat is loaded, so the next command can be taken while that beat is
    // still waiting for tready; its first beat then waits for the register to free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b1;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_count   <= '0;
            remaining     <= '0;
            pattern       <= '0;
            bad_q         <= 1'b0;
        end else begin
            frame_done <= last_hs;
            if (last_hs) begin
                frame_count <= frame_count + 32'd1;
            end

            if (cmd_valid && cmd_ready) begin
                busy <= 1'b1;
            end else if (last_hs) begin
                busy <= 1'b0;
            end

            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        remaining <= (cmd_len == '0) ? LEN_WIDTH'(1) : cmd_len;
                        pattern   <= cmd_seed;
                        bad_q     <= cmd_bad;
                        id_q      <= cmd_id;
                        dest_q    <= cmd_dest;
                        state     <= ST_SEND;
                        cmd_ready <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (load) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= DATA_WIDTH'(pattern_beat(pattern, beat_bytes));
                        m_axis_tid    <= id_q;
                        m_axis_tdest  <= dest_q;
                        pattern       <= pattern + LANES_BYTE;
                        if (is_final) begin
                            m_axis_tkeep <= final_keep;
                            m_axis_tlast <= 1'b1;
                            m_axis_tuser <= bad_q ? USER_BAD_FRAME_VALUE : '0;
                            state        <= ST_IDLE;
                            cmd_ready    <= 1'b1;
                        end else begin
                            remaining    <= remaining - LANES_LEN;
                            m_axis_tkeep <= {KEEP_WIDTH{1'b1}};
                            m_axis_tlast <= 1'b0;
                            m_axis_tuser <= '0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: a 32-bit keep-enabled instance and an
// 8-bit beat-counted instance share the command bus, selected by `sel`.
module tb_axis_frame_gen;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        logic [7:0]  id;
        logic [7:0]  dest;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        cmd_valid;
    logic [15:0] cmd_len;
    logic [7:0]  cmd_seed;
    logic [7:0]  cmd_id;
    logic [7:0]  cmd_dest;
    logic        cmd_bad;
    logic        tready;

    logic        v32, v8;
    logic        c32_ready, c8_ready;
    logic [31:0] d32_tdata;
    logic [3:0]  d32_tkeep;
    logic        d32_tvalid, d32_tlast, d32_busy, d32_done;
    logic [7:0]  d32_tid, d32_tdest;
    logic [0:0]  d32_tuser;
    logic [31:0] d32_count;
    logic [7:0]  d8_tdata;
    logic [0:0]  d8_tkeep;
    logic        d8_tvalid, d8_tlast, d8_busy, d8_done;
    logic [7:0]  d8_tid, d8_tdest;
    logic [0:0]  d8_tuser;
    logic [31:0] d8_count;

    logic        obs_ready, obs_tvalid, obs_busy, obs_done;
    logic [31:0] obs_count;
    beat_t       obs_beat;

    int          checks = 0;
    int          errors = 0;
    int          exp_count32 = 0;
    int          exp_count8 = 0;
    beat_t       exp_q[$];
    int          col_first, col_end1, col_start2, col_dones;

    assign v32 = cmd_valid && !sel;
    assign v8  = cmd_valid && sel;

    assign obs_ready  = sel ? c8_ready   : c32_ready;
    assign obs_tvalid = sel ? d8_tvalid  : d32_tvalid;
    assign obs_busy   = sel ? d8_busy    : d32_busy;
    assign obs_done   = sel ? d8_done    : d32_done;
    assign obs_count  = sel ? d8_count   : d32_count;
    assign obs_beat   = sel ? {{24'd0, d8_tdata}, {3'd0, d8_tkeep}, d8_tlast, d8_tuser[0], d8_tid, d8_tdest}
                            : {d32_tdata, d32_tkeep, d32_tlast, d32_tuser[0], d32_tid, d32_tdest};

    axis_frame_gen #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .cmd_valid(v32), .cmd_ready(c32_ready), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
        .cmd_id(cmd_id), .cmd_dest(cmd_dest), .cmd_bad(cmd_bad),
        .m_axis_tdata(d32_tdata), .m_axis_tkeep(d32_tkeep), .m_axis_tvalid(d32_tvalid),
        .m_axis_tready(tready), .m_axis_tlast(d32_tlast), .m_axis_tid(d32_tid),
        .m_axis_tdest(d32_tdest), .m_axis_tuser(d32_tuser),
        .busy(d32_busy), .frame_done(d32_done), .frame_count(d32_count)
    );

    axis_frame_gen #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .cmd_valid(v8), .cmd_ready(c8_ready), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
        .cmd_id(cmd_id), .cmd_dest(cmd_dest), .cmd_bad(cmd_bad),
        .m_axis_tdata(d8_tdata), .m_axis_tkeep(d8_tkeep), .m_axis_tvalid(d8_tvalid),
        .m_axis_tready(tready), .m_axis_tlast(d8_tlast), .m_axis_tid(d8_tid),
        .m_axis_tdest(d8_tdest), .m_axis_tuser(d8_tuser),
        .busy(d8_busy), .frame_done(d8_done), .frame_count(d8_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expands one command into the beats it must produce.
    task automatic push_frame(input int len, input logic [7:0] seed, input logic [7:0] id,
                              input logic [7:0] dest, input logic bad, input int lanes);
        int    rem;
        int    nb;
        int    b;
        beat_t e;
        rem = (len == 0) ? 1 : len;
        b   = 0;
        while (rem > 0) begin
            nb = (rem > lanes) ? lanes : rem;
            e  = '0;
            for (int k = 0; k < nb; k++) begin
                e.data[8*k +: 8] = 8'(int'(seed) + b * lanes + k);
            end
            e.keep = 4'((1 << nb) - 1);
            e.last = (rem <= lanes);
            e.user = e.last && bad;
            e.id   = id;
            e.dest = dest;
            exp_q.push_back(e);
            rem -= nb;
            b++;
        end
    endtask

    task automatic apply_stimulus(input int len, input logic [7:0] seed, input logic [7:0] id,
                                  input logic [7:0] dest, input logic bad);
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cmd_ready_before_cmd got=%b exp=1", obs_ready);
        end
        cmd_len   = 16'(len);
        cmd_seed  = seed;
        cmd_id    = id;
        cmd_dest  = dest;
        cmd_bad   = bad;
        cmd_valid = 1'b1;
        push_frame(len, seed, id, dest, bad, sel ? 1 : 4);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Drives tready (mode 0: always high, mode 1: 1,0,0,1,0,1 pattern), pops the
    // scoreboard on every handshake and checks stall stability until nframes end.
    task automatic collect(input int nframes, input int mode, input int budget);
        logic  pat [6];
        int    cyc;
        int    frames;
        logic  stalled;
        logic  in_frame;
        beat_t snap;
        beat_t e;
        pat        = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        cyc        = 0;
        frames     = 0;
        stalled    = 1'b0;
        in_frame   = 1'b0;
        col_first  = -1;
        col_end1   = -1;
        col_start2 = -1;
        col_dones  = 0;
        while (frames < nframes) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (obs_beat !== snap || obs_tvalid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL stall_hold got=%h exp=%h", obs_beat, snap);
                end
            end
            if (obs_done) col_dones++;
            tready  = (mode == 0) ? 1'b1 : pat[cyc % 6];
            stalled = obs_tvalid && !tready;
            snap    = obs_beat;
            if (obs_tvalid && tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_beat got=%h exp=none", obs_beat);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_beat !== e) begin
                        errors++;
                        $display("[TB] FAIL beat got=%h exp=%h", obs_beat, e);
                    end
                end
                if (col_first < 0) col_first = cyc;
                if (!in_frame && frames == 1 && col_start2 < 0) col_start2 = cyc;
                in_frame = 1'b1;
                if (obs_beat.last) begin
                    frames++;
                    in_frame = 1'b0;
                    if (frames == 1) col_end1 = cyc;
                end
            end
            cyc++;
            if (cyc > budget) begin
                checks++;
                errors++;
                $display("[TB] FAIL collect_timeout got=%0d frames exp=%0d", frames, nframes);
                break;
            end
        end
        @(negedge clk);
        if (obs_done) col_dones++;
        tready = 1'b1;
    endtask

    task automatic check_frame_end(input string name, input int frames, input int exp_count);
        checks++;
        if (col_dones != frames) begin
            errors++;
            $display("[TB] FAIL %s_done_pulses got=%0d exp=%0d", name, col_dones, frames);
        end
        checks++;
        if (obs_count !== 32'(exp_count)) begin
            errors++;
            $display("[TB] FAIL %s_frame_count got=%0d exp=%0d", name, obs_count, exp_count);
        end
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_busy_after got=%b exp=0", name, obs_busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_leftover_beats got=%0d exp=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({d32_tvalid, d32_busy, d32_done, d8_tvalid, d8_busy, d8_done} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got=%b exp=000000",
                     {d32_tvalid, d32_busy, d32_done, d8_tvalid, d8_busy, d8_done});
        end
        checks++;
        if (d32_count !== 32'd0 || d8_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_count got=%0d/%0d exp=0/0", d32_count, d8_count);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (c32_ready !== 1'b1 || c8_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_cmd_ready got=%b%b exp=11", c32_ready, c8_ready);
        end
    endtask

    task automatic test_partial_last();
        sel = 1'b0;
        apply_stimulus(10, 8'h10, 8'h5A, 8'h3C, 1'b0);
        checks++;
        if (obs_tvalid !== 1'b0 || obs_busy !== 1'b1 || obs_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL partial_accept_state got=%b%b%b exp=010", obs_tvalid, obs_busy, obs_ready);
        end
        collect(1, 0, 50);
        checks++;
        if (col_first != 0) begin
            errors++;
            $display("[TB] FAIL partial_latency got=%0d exp=0", col_first);
        end
        exp_count32++;
        check_frame_end("partial", 1, exp_count32);
        @(negedge clk);
        checks++;
        if (obs_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL partial_done_width got=%b exp=0", obs_done);
        end
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        apply_stimulus(10, 8'h10, 8'h11, 8'h22, 1'b0);
        collect(1, 1, 80);
        exp_count32++;
        check_frame_end("backpressure", 1, exp_count32);
    endtask

    task automatic test_bad_frame();
        sel = 1'b1;
        apply_stimulus(4, 8'h00, 8'h01, 8'h02, 1'b1);
        collect(1, 0, 50);
        exp_count8++;
        check_frame_end("bad", 1, exp_count8);
    endtask

    task automatic test_back_to_back();
        sel       = 1'b1;
        cmd_len   = 16'd1;
        cmd_seed  = 8'h20;
        cmd_id    = 8'h07;
        cmd_dest  = 8'h08;
        cmd_bad   = 1'b0;
        cmd_valid = 1'b1;
        push_frame(1, 8'h20, 8'h07, 8'h08, 1'b0, 1);
        push_frame(5, 8'h30, 8'h09, 8'h0A, 1'b0, 1);
        fork
            collect(2, 0, 100);
            begin
                @(negedge clk);
                cmd_len  = 16'd5;
                cmd_seed = 8'h30;
                cmd_id   = 8'h09;
                cmd_dest = 8'h0A;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (obs_ready) begin
                        @(negedge clk);
                        break;
                    end
                end
                cmd_valid = 1'b0;
            end
        join
        checks++;
        if (col_start2 - col_end1 != 2) begin
            errors++;
            $display("[TB] FAIL b2b_gap got=%0d exp=2", col_start2 - col_end1);
        end
        exp_count8 += 2;
        check_frame_end("b2b", 2, exp_count8);
    endtask

    task automatic test_edge_lengths();
        sel = 1'b0;
        apply_stimulus(0, 8'h77, 8'h33, 8'h44, 1'b0);
        collect(1, 0, 50);
        exp_count32++;
        check_frame_end("len0", 1, exp_count32);
        apply_stimulus(4, 8'hFE, 8'h35, 8'h46, 1'b0);
        collect(1, 0, 50);
        exp_count32++;
        check_frame_end("wrap32", 1, exp_count32);
        sel = 1'b1;
        apply_stimulus(4, 8'hFE, 8'h55, 8'h66, 1'b0);
        collect(1, 0, 50);
        exp_count8++;
        check_frame_end("wrap8", 1, exp_count8);
    endtask

    task automatic test_reset_mid_frame();
        logic found;
        sel   = 1'b1;
        found = 1'b0;
        apply_stimulus(8, 8'h40, 8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (obs_tvalid && obs_beat.data == 32'h41) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL midreset_beat2 got=absent exp=0x41");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_count8  = 0;
        exp_count32 = 0;
        checks++;
        if (obs_tvalid !== 1'b0 || obs_busy !== 1'b0 || obs_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midreset_state got=%b%b/%0d exp=00/0", obs_tvalid, obs_busy, obs_count);
        end
        apply_stimulus(8, 8'h80, 8'h13, 8'h35, 1'b0);
        collect(1, 1, 100);
        exp_count8++;
        check_frame_end("midreset", 1, exp_count8);
    endtask

    initial begin
        rst       = 1'b1;
        sel       = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_seed  = '0;
        cmd_id    = '0;
        cmd_dest  = '0;
        cmd_bad   = 1'b0;
        tready    = 1'b1;
        test_reset();
        test_partial_last();
        test_backpressure();
        test_bad_frame();
        test_back_to_back();
        test_edge_lengths();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
